// File: rtl/seg7_pkg.sv
// Purpose: shared 7-segment types and glyph constants (bit6=top .. bit0=middle, 1=lit).
// Latency: none (declarations only).
// Backpressure: none.
package seg7_pkg;

    typedef logic [6:0] seg7_pattern_t;

    localparam seg7_pattern_t SEG7_GLYPH_0 = 7'b1111110;
    localparam seg7_pattern_t SEG7_GLYPH_1 = 7'b0110000;
    localparam seg7_pattern_t SEG7_GLYPH_2 = 7'b1101101;
    localparam seg7_pattern_t SEG7_GLYPH_3 = 7'b1111001;
    localparam seg7_pattern_t SEG7_GLYPH_4 = 7'b0110011;
    localparam seg7_pattern_t SEG7_GLYPH_5 = 7'b1011011;
    localparam seg7_pattern_t SEG7_GLYPH_6 = 7'b1011111;
    localparam seg7_pattern_t SEG7_GLYPH_7 = 7'b1110000;
    localparam seg7_pattern_t SEG7_GLYPH_8 = 7'b1111111;
    localparam seg7_pattern_t SEG7_GLYPH_9 = 7'b1111011;
    localparam seg7_pattern_t SEG7_GLYPH_A = 7'b1110111;
    localparam seg7_pattern_t SEG7_GLYPH_B = 7'b0011111;
    localparam seg7_pattern_t SEG7_GLYPH_C = 7'b1001110;
    localparam seg7_pattern_t SEG7_GLYPH_D = 7'b0111101;
    localparam seg7_pattern_t SEG7_GLYPH_E = 7'b1001111;
    localparam seg7_pattern_t SEG7_GLYPH_F = 7'b1000111;
    localparam seg7_pattern_t SEG7_BLANK   = 7'b0000000;

    // Scanner tracking state: WAIT = counting towards a commit, HELD = current pair already committed.
    typedef enum logic {
        SCAN_WAIT = 1'b0,
        SCAN_HELD = 1'b1
    } scan_state_t;

endpackage

// File: rtl/encoder_7seg_pattern.sv
// Purpose: combinational lookup of a 7-segment pattern to (hex nibble, glyph hit, blank).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module encoder_7seg_pattern
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       hit_o,
    output logic       blank_o
);

    // Match the pattern against the sixteen hex glyphs; anything else is a miss.
    always_comb begin
        nibble_o = 4'h0;
        hit_o    = 1'b1;
        blank_o  = 1'b0;
        case (pattern_i)
            SEG7_GLYPH_0: nibble_o = 4'h0;
            SEG7_GLYPH_1: nibble_o = 4'h1;
            SEG7_GLYPH_2: nibble_o = 4'h2;
            SEG7_GLYPH_3: nibble_o = 4'h3;
            SEG7_GLYPH_4: nibble_o = 4'h4;
            SEG7_GLYPH_5: nibble_o = 4'h5;
            SEG7_GLYPH_6: nibble_o = 4'h6;
            SEG7_GLYPH_7: nibble_o = 4'h7;
            SEG7_GLYPH_8: nibble_o = 4'h8;
            SEG7_GLYPH_9: nibble_o = 4'h9;
            SEG7_GLYPH_A: nibble_o = 4'hA;
            SEG7_GLYPH_B: nibble_o = 4'hB;
            SEG7_GLYPH_C: nibble_o = 4'hC;
            SEG7_GLYPH_D: nibble_o = 4'hD;
            SEG7_GLYPH_E: nibble_o = 4'hE;
            SEG7_GLYPH_F: nibble_o = 4'hF;
            SEG7_BLANK: begin
                hit_o   = 1'b0;
                blank_o = 1'b1;
            end
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/encoder_7seg_scan.sv
// Purpose: recover hex digits from an observed multiplexed 7-segment scan (optional ENCODER_7SEG_ACTIVE_LOW_EN inverts seg/sel).
// Latency: value/digit_valid update STABLE_CYCLES edges after a stable pair appears; update/err one edge later.
// Backpressure: none; the observed display is free-running and every cycle is sampled.
module encoder_7seg_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     sel,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  err
);

    localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]        CNT_MAX    = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]        CNT_COMMIT = 8'(STABLE_CYCLES - 2);
    localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);

    // Polarity-normalised inputs: everything downstream sees 1 = lit / selected.
    logic [6:0]        seg_in;
    logic [DIGITS-1:0] sel_in;

`ifdef ENCODER_7SEG_ACTIVE_LOW_EN
    assign seg_in = ~seg;
    assign sel_in = ~sel;
`else
    assign seg_in = seg;
    assign sel_in = sel;
`endif

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] sel_q;
    logic [7:0]        cnt_q, cnt_d;
    scan_state_t       state_q;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0] valid_q;
    logic              upd_pend_q, err_pend_q;
    logic              update_q, err_q;

    logic              same_pair, sel_onehot, stable, commit;
    logic [IDX_W-1:0]  sel_idx;
    logic [3:0]        dec_nib, old_nib, new_nib;
    logic              dec_hit, dec_blank;
    logic              old_vld, new_vld, bad_glyph, altered;

    assign same_pair  = (seg_in == seg_q) && (sel_in == sel_q);
    assign sel_onehot = (sel_in != '0) && ((sel_in & (sel_in - SEL_ONE)) == '0);
    assign stable     = same_pair && sel_onehot;

    // Saturating count of consecutive edges on which the pair repeated.
    always_comb begin
        cnt_d = cnt_q;
        if (!stable) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Sample stage and stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 7'd0;
            sel_q <= '0;
            cnt_q <= 8'd0;
        end else begin
            seg_q <= seg_in;
            sel_q <= sel_in;
            cnt_q <= cnt_d;
        end
    end

    // Position of the single set select bit (only meaningful when sel is one-hot).
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_in[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    encoder_7seg_pattern u_pattern (
        .pattern_i (seg_in),
        .nibble_o  (dec_nib),
        .hit_o     (dec_hit),
        .blank_o   (dec_blank)
    );

    assign old_nib = value_q[4*sel_idx +: 4];
    assign old_vld = valid_q[sel_idx];

    // Slot contents a commit would write; blank and bad patterns keep the old nibble.
    always_comb begin
        new_nib   = old_nib;
        new_vld   = 1'b0;
        bad_glyph = 1'b0;
        if (dec_hit) begin
            new_nib = dec_nib;
            new_vld = 1'b1;
        end else if (!dec_blank) begin
            bad_glyph = 1'b1;
        end
    end

    assign altered = (new_nib != old_nib) || (new_vld != old_vld);

    // The edge that completes STABLE_CYCLES identical one-hot samples commits once.
    assign commit = (state_q == SCAN_WAIT) && stable && (cnt_q == CNT_COMMIT);

    // WAIT/HELD tracker with registered slot updates; update/err are delayed one edge via pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCAN_WAIT;
            value_q    <= '0;
            valid_q    <= '0;
            upd_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            update_q   <= upd_pend_q;
            err_q      <= err_pend_q;
            upd_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
            case (state_q)
                SCAN_WAIT: begin
                    if (commit) begin
                        state_q                <= SCAN_HELD;
                        value_q[4*sel_idx +: 4] <= new_nib;
                        valid_q[sel_idx]       <= new_vld;
                        upd_pend_q             <= altered;
                        err_pend_q             <= bad_glyph;
                    end
                end
                SCAN_HELD: begin
                    if (!stable) begin
                        state_q <= SCAN_WAIT;
                    end
                end
                default: state_q <= SCAN_WAIT;
            endcase
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign err         = err_q;

endmodule

// File: tb/tb_encoder_7seg_scan.sv
// Purpose: table-driven self-checking bench for encoder_7seg_scan with an update scoreboard.
// Latency: checks commit at edge STABLE_CYCLES and update/err one edge later.
// Backpressure: none; stimulus is applied at falling edges, outputs sampled there too.
`timescale 1ns/1ps
module tb_encoder_7seg_scan;

    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        update;
    logic        err;

    encoder_7seg_scan #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .sel         (sel),
        .value       (value),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        int         n;
        bit         commit;
        logic [3:0] nib;
        bit         vld;
        bit         bad;
    } step_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  valid;
    } snap_t;

    snap_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    int          err_exp  = 0;
    logic [15:0] m_value;
    logic [3:0]  m_valid;
    bit          mon_en   = 1'b0;
    step_t       steps[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [6:0] g);
`ifdef ENCODER_7SEG_ACTIVE_LOW_EN
        sel = ~s;
        seg = ~g;
`else
        sel = s;
        seg = g;
`endif
    endtask

    // Scoreboard: every update pulse must match the oldest expected snapshot.
    always @(negedge clk) begin : monitor
        snap_t e;
        if (mon_en) begin
            if (err === 1'b1) err_seen++;
            if (update === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: got pulse, expected none (value=%0h valid=%0h)", value, digit_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("upd_value", 32'(value), 32'(e.value));
                    check("upd_valid", 32'(digit_valid), 32'(e.valid));
                end
            end
        end
    end

    // Apply one step: push the expected outcome, hold the pair, check commit timing.
    task automatic run_step(input step_t st);
        int          slot;
        logic [15:0] old_v, new_v;
        logic [3:0]  old_d, new_d;
        bit          changed;
        old_v   = m_value;
        old_d   = m_valid;
        new_v   = old_v;
        new_d   = old_d;
        changed = 1'b0;
        if (st.commit) begin
            slot = 0;
            for (int i = 0; i < 4; i++) if (st.sel[i]) slot = i;
            new_d[slot] = st.vld;
            if (st.vld) new_v[slot*4 +: 4] = st.nib;
            changed = (new_v != old_v) || (new_d != old_d);
            if (changed) exp_q.push_back('{value: new_v, valid: new_d});
            if (st.bad) err_exp++;
        end
        drive(st.sel, st.seg);
        for (int k = 1; k <= st.n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (st.commit && k == S - 1) begin
                check("pre_commit_value", 32'(value), 32'(old_v));
                check("pre_commit_valid", 32'(digit_valid), 32'(old_d));
            end
            if (st.commit && k == S) begin
                check("commit_value", 32'(value), 32'(new_v));
                check("commit_valid", 32'(digit_valid), 32'(new_d));
                check("update_not_early", 32'(update), 32'(0));
            end
            if (st.commit && k == S + 1) begin
                check("update_pulse", 32'(update), 32'(changed));
                check("err_pulse", 32'(err), 32'(st.bad));
            end
        end
        if (!st.commit) begin
            check("hold_value", 32'(value), 32'(old_v));
            check("hold_valid", 32'(digit_valid), 32'(old_d));
        end
        m_value = new_v;
        m_valid = new_d;
    endtask

    initial begin
        steps[0]  = '{4'b0001, 7'b1111001,  5, 1'b1, 4'h3, 1'b1, 1'b0};
        steps[1]  = '{4'b0001, 7'b1111110,  5, 1'b1, 4'h0, 1'b1, 1'b0};
        steps[2]  = '{4'b0010, 7'b1110111,  5, 1'b1, 4'hA, 1'b1, 1'b0};
        steps[3]  = '{4'b0100, 7'b0011111,  5, 1'b1, 4'hB, 1'b1, 1'b0};
        steps[4]  = '{4'b1000, 7'b1000111,  5, 1'b1, 4'hF, 1'b1, 1'b0};
        steps[5]  = '{4'b0010, 7'b1110111,  3, 1'b0, 4'h0, 1'b0, 1'b0};
        steps[6]  = '{4'b0100, 7'b1010101,  5, 1'b1, 4'h0, 1'b0, 1'b1};
        steps[7]  = '{4'b0100, 7'b0000000,  5, 1'b1, 4'h0, 1'b0, 1'b0};
        steps[8]  = '{4'b0011, 7'b1111001, 10, 1'b0, 4'h0, 1'b0, 1'b0};
        steps[9]  = '{4'b0000, 7'b1111111,  6, 1'b0, 4'h0, 1'b0, 1'b0};
        steps[10] = '{4'b0100, 7'b1111111,  5, 1'b1, 4'h8, 1'b1, 1'b0};
        steps[11] = '{4'b0001, 7'b1111110,  5, 1'b1, 4'h0, 1'b1, 1'b0};
        steps[12] = '{4'b1000, 7'b0000000,  5, 1'b1, 4'h0, 1'b0, 1'b0};
        steps[13] = '{4'b0010, 7'b0111101,  8, 1'b1, 4'hD, 1'b1, 1'b0};
        steps[14] = '{4'b0001, 7'b1011011,  4, 1'b1, 4'h5, 1'b1, 1'b0};
        steps[15] = '{4'b0010, 7'b1001110,  4, 1'b1, 4'hC, 1'b1, 1'b0};
        steps[16] = '{4'b0100, 7'b0110011,  5, 1'b1, 4'h4, 1'b1, 1'b0};

        reset = 1'b1;
        drive(4'b0000, 7'b0000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_value", 32'(value), 32'(0));
        check("reset_valid", 32'(digit_valid), 32'(0));
        check("reset_update", 32'(update), 32'(0));
        check("reset_err", 32'(err), 32'(0));
        reset   = 1'b0;
        m_value = 16'h0;
        m_valid = 4'h0;
        mon_en  = 1'b1;

        for (int i = 0; i < 5; i++) run_step(steps[i]);
        check("scan_value", 32'(value), 32'(16'hFBA0));
        check("scan_valid", 32'(digit_valid), 32'(4'hF));
        for (int i = 5; i < 17; i++) run_step(steps[i]);
        check("table_final_value", 32'(value), 32'(16'hF4C5));

        // Reset in the middle of a valid run discards the partial count.
        run_step('{4'b0010, 7'b0110000, 2, 1'b0, 4'h0, 1'b0, 1'b0});
        check("pending_before_reset", 32'(exp_q.size()), 32'(0));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_value", 32'(value), 32'(0));
        check("midreset_valid", 32'(digit_valid), 32'(0));
        check("midreset_update", 32'(update), 32'(0));
        check("midreset_err", 32'(err), 32'(0));
        reset   = 1'b0;
        m_value = 16'h0;
        m_valid = 4'h0;
        run_step('{4'b0010, 7'b0110000, 5, 1'b1, 4'h1, 1'b1, 1'b0});
        check("after_reset_value", 32'(value), 32'(16'h0010));

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        check("err_pulse_count", 32'(err_seen), 32'(err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_7seg_scan.md
ENCODER_7SEG_SCAN -- requirements
Module: encoder_7seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits observed (range 1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical samples required before commit (range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port seg  input  7  observed segment pattern; bit 6=top, 5=upper-right, 4=lower-right, 3=bottom, 2=lower-left, 1=upper-left, 0=middle; 1=lit.
REQ-006 SHALL have port sel  input  DIGITS  one-hot digit enable of the scanned display; bit i=digit i.
REQ-007 SHALL have port value  output  4*DIGITS  recovered hex nibbles; digit i at value[4i+3:4i].
REQ-008 SHALL have port digit_valid  output  DIGITS  per-digit flag; 1=nibble i holds a decoded pattern.
REQ-009 SHALL have port update  output  1  one-cycle pulse when value or digit_valid changed at the previous edge.
REQ-010 SHALL have port err  output  1  one-cycle pulse when a committed pattern is not a hex glyph and not blank.

Function
REQ-011 SHALL register (seg, sel) each cycle into a sample stage; counting compares the incoming pair with the sample stage.
REQ-012 SHALL keep a saturating stability counter: cleared when the incoming pair differs from the sample or sel is not one-hot; otherwise incremented up to STABLE_CYCLES-1.
REQ-013 SHALL use two states, WAIT and HELD; reset enters WAIT.
REQ-014 WAIT -> HELD SHALL occur on the edge at which the same one-hot (seg, sel) has been presented on STABLE_CYCLES consecutive edges; this is the commit edge.
REQ-015 HELD -> WAIT SHALL occur on the first edge where the incoming pair differs or sel is not one-hot; no second commit happens while in HELD.
REQ-016 At commit, pattern SHALL be decoded with the hex glyph table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-017 On a glyph match, commit SHALL write the nibble to slot i (the index of the set sel bit) and set digit_valid[i].
REQ-018 On blank (0000000), commit SHALL clear digit_valid[i], retain the old nibble, and assert no err.
REQ-019 On any other pattern, commit SHALL clear digit_valid[i], retain the nibble, and pulse err on the edge after the commit.
REQ-020 value/digit_valid SHALL change only at commit edges; update SHALL pulse exactly one cycle after a commit that alters either, and never for an identical recommit.
REQ-021 sel all-zero or multi-hot SHALL never commit and SHALL never modify any slot.
REQ-022 Minimum latency from the first edge of a stable input to visible value SHALL be STABLE_CYCLES edges; update/err follow one edge later.

Reset
REQ-023 reset SHALL drive value=0, digit_valid=0, update=0, err=0, counter=0, sample stage=0, state=WAIT on the next edge.
REQ-024 Reset asserted mid-count SHALL discard the partial count; counting restarts from the first edge after reset deasserts.

Configuration
REQ-025 Macro ENCODER_7SEG_ACTIVE_LOW_EN: when defined, seg and sel SHALL be inverted at the input (common-anode display, 0=lit/selected) before all other logic; when undefined, inputs are active-high per REQ-005/006.

Structure
REQ-026 Package seg7_pkg SHALL hold the seg7_pattern_t typedef (7 bits), the 16 glyph constants, and the blank constant, shared with the existing decoder.
REQ-027 Sub-module encoder_7seg_pattern SHALL be the combinational pattern->(nibble, hit, blank) lookup; all sequential logic remains in encoder_7seg_scan.

Verification
REQ-028 Reset then sel=0001, seg=1111001 held 4 edges -> value[3:0]=3, digit_valid=0001 after edge 4; update pulses one edge later.
REQ-029 Scan digits 0..3 with 0,A,b,F (1111110, 1110111, 0011111, 1000111), each held 5 edges -> value=16'hFbA0 (digit3..0 = F,b,A,0), digit_valid=1111, four update pulses.
REQ-030 sel=0010, seg=1110111 held only 3 edges then changed -> no commit, value and digit_valid unchanged, no update.
REQ-031 sel=0100, seg=1010101 held 4 edges -> digit_valid[2]=0, nibble kept, err single pulse; seg=0000000 held 4 edges -> no err.
REQ-032 sel=0011 held 10 edges -> no change; reset asserted at count 2 of a valid run -> all outputs 0, new run needs full 4 edges.
REQ-033 With ENCODER_7SEG_ACTIVE_LOW_EN, sel=1110, seg=0000110 held 4 edges -> value[3:0]=3, digit_valid[0]=1.
